// File: rtl/laser_pkg.sv
// laser_pkg: shared FSM state type, default timing constants and MISO/MOSI bit indices for the laser fire path.
package laser_pkg;
  typedef enum logic [2:0] {IDLE, ARM, FIRE, DONE, COOLDOWN} fire_state_t;
  localparam int DEF_ARM_CYCLES = 200_000;
  localparam int DEF_FIRE_CYCLES = 5_000_000;
  localparam int DEF_COOLDOWN_CYCLES = 50_000_000;
  localparam int DEF_CNT_W = 26;
  localparam int MISO_TGT_BIT = 11;
  localparam int MISO_DONE_BIT = 10;
  localparam int MOSI_FIRE_BIT = 13;
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return v + {7'd0, ~&v};
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: W-bit two-flop synchroniser with asynchronous active-high reset.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] m;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) {q, m} <= '0;
    else {q, m} <= {m, d};
  end
endmodule

// File: rtl/laser_fire_sequencer.sv
// laser_fire_sequencer: turns the STM32 fire command into an interlocked, timed laser pulse with cooldown and shot/abort counters.
module laser_fire_sequencer
  import laser_pkg::*;
#(
  parameter int ARM_CYCLES = DEF_ARM_CYCLES,
  parameter int FIRE_CYCLES = DEF_FIRE_CYCLES,
  parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mosi_valid,
  input  logic       fire_flag,
  input  logic       center_hit,
  input  logic       red_detect,
  output logic       laser_out,
  output logic       target_on_box,
  output logic       fire_complete,
  output logic       busy,
  output logic [7:0] shot_count,
  output logic [7:0] abort_count
);
  localparam logic [CNT_W-1:0] ARM_LD = CNT_W'(ARM_CYCLES - 1);
  localparam logic [CNT_W-1:0] FIRE_LD = CNT_W'(FIRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LD = CNT_W'(COOLDOWN_CYCLES - 1);
  fire_state_t state;
  logic [CNT_W-1:0] cnt;
  logic [1:0] ilk;
  logic red_s, req_q, req_prev, req_d, req_rise, armed;
  sync_2ff #(.W(2)) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    ({red_detect, center_hit}),
    .q    (ilk)
  );
  assign target_on_box = ilk[0];
  assign red_s = ilk[1];
  // req_d is the request as it will be after this edge, so a cancel frame wins over an ARM timeout in the same cycle
  assign req_d = mosi_valid ? fire_flag : req_q;
  assign req_rise = req_q & ~req_prev;
  assign armed = target_on_box & red_s;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      req_q <= 1'b0;
      req_prev <= 1'b0;
      laser_out <= 1'b0;
      fire_complete <= 1'b0;
      busy <= 1'b0;
      shot_count <= '0;
      abort_count <= '0;
    end else begin
      req_q <= req_d;
      req_prev <= req_q;
      laser_out <= state == FIRE;
      cnt <= cnt - CNT_W'(cnt != '0);
      case (state)
        IDLE: begin
          if (req_rise && armed) begin
            state <= ARM;
            cnt <= ARM_LD;
            busy <= 1'b1;
          end else if (req_rise) begin
            abort_count <= sat_inc(abort_count);
          end
        end
        ARM: begin
          if (!armed) begin
            state <= IDLE;
            busy <= 1'b0;
            abort_count <= sat_inc(abort_count);
          end else if (!req_d) begin
            state <= IDLE;
            busy <= 1'b0;
          end else if (cnt == '0) begin
            state <= FIRE;
            cnt <= FIRE_LD;
          end
        end
        FIRE: begin
          if (cnt == '0) begin
            state <= DONE;
            fire_complete <= 1'b1;
            shot_count <= shot_count + 8'd1;
          end
        end
        DONE: begin
          if (mosi_valid && !fire_flag) begin
            state <= COOLDOWN;
            cnt <= COOL_LD;
            fire_complete <= 1'b0;
          end
        end
        COOLDOWN: begin
          if (cnt == '0) begin
            state <= IDLE;
            busy <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_laser_fire_sequencer.sv
// tb_laser_fire_sequencer: directed scenarios with a pulse/abort/shot scoreboard checked by an independent monitor.
module tb_laser_fire_sequencer;
  typedef struct {
    int rise;
    int width;
  } pulse_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mosi_valid = 1'b0;
  logic fire_flag = 1'b0;
  logic center_hit = 1'b0;
  logic red_detect = 1'b0;
  logic laser_out, target_on_box, fire_complete, busy;
  logic [7:0] shot_count, abort_count;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  pulse_t pulse_q[$];
  int abort_q[$];
  int shot_q[$];
  laser_fire_sequencer #(
    .ARM_CYCLES(8),
    .FIRE_CYCLES(16),
    .COOLDOWN_CYCLES(32),
    .CNT_W(26)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mosi_valid   (mosi_valid),
    .fire_flag    (fire_flag),
    .center_hit   (center_hit),
    .red_detect   (red_detect),
    .laser_out    (laser_out),
    .target_on_box(target_on_box),
    .fire_complete(fire_complete),
    .busy         (busy),
    .shot_count   (shot_count),
    .abort_count  (abort_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask
  // monitor: pops expectations whenever the DUT produces a pulse, an abort or a shot
  pulse_t e;
  int rise_c = 0;
  logic lp = 1'b0;
  logic [7:0] ap = '0, sp = '0;
  always @(negedge clk) begin
    if (laser_out === 1'b1 && lp === 1'b0) rise_c = cyc;
    if (laser_out === 1'b0 && lp === 1'b1) begin
      if (pulse_q.size() == 0) chk("unexpected_pulse_at", rise_c, -1);
      else begin
        e = pulse_q.pop_front();
        chk("pulse_rise", rise_c, e.rise);
        chk("pulse_width", cyc - rise_c, e.width);
      end
    end
    if (reset === 1'b0) begin
      if (abort_count !== ap) begin
        if (abort_q.size() == 0) chk("unexpected_abort", int'(abort_count), int'(ap));
        else chk("abort_count", int'(abort_count), abort_q.pop_front());
      end
      if (shot_count !== sp) begin
        if (shot_q.size() == 0) chk("unexpected_shot", int'(shot_count), int'(sp));
        else chk("shot_count", int'(shot_count), shot_q.pop_front());
      end
    end
    lp = laser_out;
    ap = abort_count;
    sp = shot_count;
  end
  task automatic send_frame(input logic f, output int t);
    mosi_valid = 1'b1;
    fire_flag = f;
    @(negedge clk);
    mosi_valid = 1'b0;
    fire_flag = 1'b0;
    t = cyc;
  endtask
  task automatic do_reset();
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
  endtask
  task automatic wait_fc();
    for (int i = 0; i < 200 && fire_complete !== 1'b1; i++) @(negedge clk);
    chk("fire_complete_wait", int'(fire_complete), 1);
  endtask
  task automatic interlocks(input logic c, input logic r);
    center_hit = c;
    red_detect = r;
    repeat (4) @(negedge clk);
  endtask
  task automatic fire_shot(input int exp_shot);
    int t0, ta;
    send_frame(1'b1, t0);
    pulse_q.push_back('{rise: t0 + 10, width: 16});
    shot_q.push_back(exp_shot);
    wait_fc();
    send_frame(1'b0, ta);
    repeat (33) @(negedge clk);
  endtask
  initial begin
    int t0, ta;
    repeat (2) @(negedge clk);
    chk("rst_laser", int'(laser_out), 0);
    chk("rst_tob", int'(target_on_box), 0);
    chk("rst_fc", int'(fire_complete), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_shot", int'(shot_count), 0);
    chk("rst_abort", int'(abort_count), 0);
    #1 reset = 1'b0;
    @(negedge clk);
    // 1: happy path and cooldown length
    interlocks(1'b1, 1'b1);
    chk("tob_high", int'(target_on_box), 1);
    send_frame(1'b1, t0);
    pulse_q.push_back('{rise: t0 + 10, width: 16});
    shot_q.push_back(1);
    @(negedge clk);
    chk("busy_arm", int'(busy), 1);
    wait_fc();
    chk("fc_cycle", cyc, t0 + 25);
    send_frame(1'b0, ta);
    chk("fc_cleared", int'(fire_complete), 0);
    repeat (31) @(negedge clk);
    chk("busy_cool_end", int'(busy), 1);
    @(negedge clk);
    chk("busy_idle", int'(busy), 0);
    // 2: interlock lost during ARM
    do_reset();
    interlocks(1'b1, 1'b1);
    abort_q.push_back(1);
    send_frame(1'b1, t0);
    repeat (4) @(negedge clk);
    center_hit = 1'b0;
    @(negedge clk);
    chk("tob_lag1", int'(target_on_box), 1);
    @(negedge clk);
    chk("tob_lag2", int'(target_on_box), 0);
    chk("busy_pre_abort", int'(busy), 1);
    @(negedge clk);
    chk("busy_abort", int'(busy), 0);
    center_hit = 1'b1;
    send_frame(1'b0, t0);
    repeat (30) @(negedge clk);
    chk("abort2_final", int'(abort_count), 1);
    // 3: request with red interlock low
    do_reset();
    interlocks(1'b1, 1'b0);
    abort_q.push_back(1);
    send_frame(1'b1, t0);
    repeat (2) @(negedge clk);
    chk("noilk_busy", int'(busy), 0);
    chk("noilk_abort", int'(abort_count), 1);
    send_frame(1'b0, t0);
    repeat (20) @(negedge clk);
    // 4: held request does not re-fire
    do_reset();
    interlocks(1'b1, 1'b1);
    send_frame(1'b1, t0);
    pulse_q.push_back('{rise: t0 + 10, width: 16});
    shot_q.push_back(1);
    wait_fc();
    send_frame(1'b1, t0);
    repeat (3) @(negedge clk);
    chk("done_holds", int'(fire_complete), 1);
    send_frame(1'b0, ta);
    send_frame(1'b1, t0);
    repeat (50) @(negedge clk);
    chk("held_idle", int'(busy), 0);
    chk("held_one_shot", int'(shot_count), 1);
    send_frame(1'b0, t0);
    fire_shot(2);
    // cancel in the same cycle the ARM timeout completes
    do_reset();
    interlocks(1'b1, 1'b1);
    send_frame(1'b1, t0);
    repeat (8) @(negedge clk);
    send_frame(1'b0, ta);
    chk("cancel_busy", int'(busy), 0);
    repeat (30) @(negedge clk);
    chk("cancel_no_abort", int'(abort_count), 0);
    chk("cancel_no_shot", int'(shot_count), 0);
    // 5: reset during FIRE
    do_reset();
    interlocks(1'b1, 1'b1);
    send_frame(1'b1, t0);
    pulse_q.push_back('{rise: t0 + 10, width: 5});
    repeat (14) @(negedge clk);
    chk("fire_c5_laser", int'(laser_out), 1);
    #1 reset = 1'b1;
    #1;
    chk("rst_fire_laser", int'(laser_out), 0);
    chk("rst_fire_busy", int'(busy), 0);
    chk("rst_fire_tob", int'(target_on_box), 0);
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("post_rst_idle", int'(busy), 0);
    chk("post_rst_shot", int'(shot_count), 0);
    // 6: shot_count wrap and abort_count saturation
    do_reset();
    interlocks(1'b1, 1'b1);
    for (int i = 1; i <= 256; i++) fire_shot(i % 256);
    chk("shot_wrap", int'(shot_count), 0);
    interlocks(1'b1, 1'b0);
    for (int i = 1; i <= 300; i++) begin
      if (i <= 255) abort_q.push_back(i);
      send_frame(1'b1, t0);
      send_frame(1'b0, t0);
    end
    repeat (5) @(negedge clk);
    chk("abort_sat", int'(abort_count), 255);
    chk("pulse_q_left", pulse_q.size(), 0);
    chk("abort_q_left", abort_q.size(), 0);
    chk("shot_q_left", shot_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule
